// File: rtl/mips_pkg.sv
// Shared fetch/decode definitions: field widths, the NOP encoding, the fetch entry
// layout and the skid-buffer state encoding (state value doubles as occupancy).
package mips_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/if_id_skid_reg_if.sv
// Fetch-to-decode handshake bundle. Transfer rules: an input entry moves when
// in_valid & in_ready at a posedge; an output entry moves when out_valid & out_ready at a posedge.
interface if_id_skid_reg_if #(
    parameter int PC_W    = mips_pkg::PC_W,
    parameter int INSTR_W = mips_pkg::INSTR_W
) ();

    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;

    // master = fetch + decode environment, slave = the pipeline register
    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr
    );

endinterface

// File: rtl/pipe_reg_en.sv
// W-bit register with synchronous reset value and load enable.
module pipe_reg_en #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer; in_ready and all out_* come
// straight from flops so fetch never sees a combinational path from decode.
module if_id_skid_reg
    import mips_pkg::*;
#(
    parameter int                 PC_W    = mips_pkg::PC_W,
    parameter int                 INSTR_W = mips_pkg::INSTR_W,
    parameter logic [INSTR_W-1:0] NOP     = INSTR_W'(NOP_INSTR)
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              flush,
    if_id_skid_reg_if.slave   bus,
    output logic [1:0]        occupancy
);

    localparam int W = PC_W + INSTR_W;

    skid_state_t  state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic         in_xfer, out_xfer;
    logic         main_en, skid_en, main_from_skid;
    logic [W-1:0] main_d, main_q, skid_q, in_entry;

    assign in_entry = {bus.in_pc, bus.in_instr};
    assign in_xfer  = bus.in_valid & in_ready_q;
    assign out_xfer = (state_q != EMPTY) & bus.out_ready;

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_en = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_en = 1'b1;
                end else if (in_xfer) begin
                    skid_en = 1'b1;
                    state_d = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Redirect: drop everything, including a same-cycle input; a same-cycle output is already consumed.
        if (flush) begin
            state_d = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
        in_ready_d = (state_d != FULL);
    end

    assign main_d = main_from_skid ? skid_q : in_entry;

    pipe_reg_en #(.W(W), .RST_VAL('0)) u_main (
        .clk (clk),
        .rst (arst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    pipe_reg_en #(.W(W), .RST_VAL('0)) u_skid (
        .clk (clk),
        .rst (arst),
        .en  (skid_en),
        .d   (in_entry),
        .q   (skid_q)
    );

    // out_pc keeps its last value when invalid; only the instruction is squashed to NOP
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_pc    = main_q[W-1:INSTR_W];
    assign bus.out_instr = (state_q != EMPTY) ? main_q[INSTR_W-1:0] : NOP;
    assign occupancy     = state_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed and random checks of the IF/ID skid register against hand-computed values
// and a FIFO reference queue.
module tb_if_id_skid_reg;
    import mips_pkg::*;

    logic       clk;
    logic       arst;
    logic       flush;
    logic [1:0] occupancy;
    int         checks;
    int         failures;

    if_id_skid_reg_if #(.PC_W(32), .INSTR_W(32)) bus ();

    if_id_skid_reg dut (
        .clk       (clk),
        .arst      (arst),
        .flush     (flush),
        .bus       (bus.slave),
        .occupancy (occupancy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        bus.in_valid = v;
        bus.in_pc    = pc;
        bus.in_instr = instr;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];

    localparam logic [31:0] I_A = 32'h2401_0001;
    localparam logic [31:0] I_B = 32'h2402_0002;
    localparam logic [31:0] I_C = 32'h2403_0003;

    initial begin
        checks    = 0;
        failures  = 0;
        arst      = 1'b1;
        flush     = 1'b0;
        bus.out_ready = 1'b0;
        drive_in(1'b1, 32'h40, 32'h8C01_0004);

        // 1. reset with in_valid asserted
        step();
        step();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_instr", 64'(bus.out_instr), 64'h0);
        check("rst_out_pc",    64'(bus.out_pc),    64'h0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_occ",       64'(occupancy),     64'd0);
        arst = 1'b0;
        drive_in(1'b0, 32'h0, 32'h0);
        step();
        check("idle_out_valid", 64'(bus.out_valid), 64'd0);

        // 2. back-to-back stream
        bus.out_ready = 1'b1;
        drive_in(1'b1, 32'h00, I_A);
        step();
        check("s_a_valid", 64'(bus.out_valid), 64'd1);
        check("s_a_pc",    64'(bus.out_pc),    64'h00);
        check("s_a_instr", 64'(bus.out_instr), 64'(I_A));
        check("s_a_rdy",   64'(bus.in_ready),  64'd1);
        drive_in(1'b1, 32'h04, I_B);
        step();
        check("s_b_pc",    64'(bus.out_pc),    64'h04);
        check("s_b_instr", 64'(bus.out_instr), 64'(I_B));
        check("s_b_rdy",   64'(bus.in_ready),  64'd1);
        drive_in(1'b1, 32'h08, I_C);
        step();
        check("s_c_pc",    64'(bus.out_pc),    64'h08);
        check("s_c_instr", 64'(bus.out_instr), 64'(I_C));
        check("s_c_occ",   64'(occupancy),     64'd1);
        drive_in(1'b0, 32'h0, 32'h0);
        step();
        check("s_end_valid", 64'(bus.out_valid), 64'd0);
        check("s_end_nop",   64'(bus.out_instr), 64'h0);
        check("s_end_pc",    64'(bus.out_pc),    64'h08);

        // 3. stall fills skid, then drain in order
        bus.out_ready = 1'b0;
        drive_in(1'b1, 32'h10, 32'h1111_0010);
        step();
        check("st1_occ", 64'(occupancy), 64'd1);
        drive_in(1'b1, 32'h14, 32'h1111_0014);
        step();
        check("st2_occ",   64'(occupancy),     64'd2);
        check("st2_rdy",   64'(bus.in_ready),  64'd0);
        check("st2_pc",    64'(bus.out_pc),    64'h10);
        drive_in(1'b1, 32'h99, 32'hDEAD_BEEF);
        step();
        check("st3_hold_pc",    64'(bus.out_pc),    64'h10);
        check("st3_hold_instr", 64'(bus.out_instr), 64'h1111_0010);
        check("st3_occ",        64'(occupancy),     64'd2);
        drive_in(1'b0, 32'h0, 32'h0);
        bus.out_ready = 1'b1;
        step();
        check("dr1_pc",    64'(bus.out_pc),    64'h14);
        check("dr1_instr", 64'(bus.out_instr), 64'h1111_0014);
        check("dr1_rdy",   64'(bus.in_ready),  64'd1);
        check("dr1_occ",   64'(occupancy),     64'd1);
        step();
        check("dr2_valid", 64'(bus.out_valid), 64'd0);

        // 4. flush while FULL with in_valid
        bus.out_ready = 1'b0;
        drive_in(1'b1, 32'h20, 32'h2222_0020);
        step();
        drive_in(1'b1, 32'h24, 32'h2222_0024);
        step();
        check("fl_pre_occ", 64'(occupancy), 64'd2);
        drive_in(1'b1, 32'h18, 32'h2222_0018);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive_in(1'b0, 32'h0, 32'h0);
        check("fl_valid", 64'(bus.out_valid), 64'd0);
        check("fl_nop",   64'(bus.out_instr), 64'h0);
        check("fl_occ",   64'(occupancy),     64'd0);
        check("fl_rdy",   64'(bus.in_ready),  64'd1);
        bus.out_ready = 1'b1;
        step();
        check("fl_after_valid", 64'(bus.out_valid), 64'd0);

        // flush in BUSY with an accepted-looking input: the input is dropped
        drive_in(1'b1, 32'h30, 32'h3333_0030);
        bus.out_ready = 1'b0;
        step();
        drive_in(1'b1, 32'h34, 32'h3333_0034);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive_in(1'b0, 32'h0, 32'h0);
        check("flb_occ",   64'(occupancy),     64'd0);
        check("flb_valid", 64'(bus.out_valid), 64'd0);

        // 5. reset while FULL
        drive_in(1'b1, 32'h40, 32'h4444_0040);
        step();
        drive_in(1'b1, 32'h44, 32'h4444_0044);
        step();
        check("rm_pre_occ", 64'(occupancy), 64'd2);
        drive_in(1'b0, 32'h0, 32'h0);
        arst = 1'b1;
        bus.out_ready = 1'b1;
        step();
        arst = 1'b0;
        check("rm_valid", 64'(bus.out_valid), 64'd0);
        check("rm_occ",   64'(occupancy),     64'd0);
        check("rm_pc",    64'(bus.out_pc),    64'h0);
        check("rm_rdy",   64'(bus.in_ready),  64'd1);
        step();
        check("rm_after_valid", 64'(bus.out_valid), 64'd0);

        // 6. random valid/ready against the reference FIFO
        exp_q.delete();
        begin
            logic [31:0] next_pc;
            logic        in_x, out_x, fl;
            next_pc = 32'h1000;
            for (int cyc = 0; cyc < 10000; cyc++) begin
                fl = ($urandom_range(0, 63) == 0);
                flush = fl;
                bus.out_ready = ($urandom_range(0, 3) != 0);
                drive_in(($urandom_range(0, 2) != 0), next_pc, $urandom());
                #1;
                check("r_rdy",   64'(bus.in_ready),  64'(exp_q.size() < 2));
                check("r_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
                check("r_occ",   64'(occupancy),     64'(exp_q.size()));
                if (exp_q.size() > 0) begin
                    check("r_data", {bus.out_pc, bus.out_instr}, exp_q[0]);
                end else begin
                    check("r_nop", 64'(bus.out_instr), 64'h0);
                end
                in_x  = bus.in_valid && (exp_q.size() < 2);
                out_x = (exp_q.size() > 0) && bus.out_ready;
                if (out_x) void'(exp_q.pop_front());
                if (fl) begin
                    exp_q.delete();
                end else if (in_x) begin
                    exp_q.push_back({bus.in_pc, bus.in_instr});
                end
                if (in_x) next_pc = next_pc + 32'd4;
                step();
            end
            flush = 1'b0;
            drive_in(1'b0, 32'h0, 32'h0);
            bus.out_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                #1;
                if (exp_q.size() > 0) begin
                    check("r_drain", {bus.out_pc, bus.out_instr}, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                step();
            end
            check("r_final_valid", 64'(bus.out_valid), 64'd0);
        end

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
